// File: rtl/irq_pkg.sv
// Shared register map and gateway mode encoding for the interrupt controller.
package irq_pkg;

    localparam logic [7:0] ADDR_ENABLE    = 8'h00;
    localparam logic [7:0] ADDR_MODE      = 8'h01;
    localparam logic [7:0] ADDR_THRESH    = 8'h02;
    localparam logic [7:0] ADDR_PEND      = 8'h03;
    localparam logic [7:0] ADDR_INSVC     = 8'h04;
    localparam logic [7:0] ADDR_PRIO_BASE = 8'h10;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } mode_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source front end: two-flop synchroniser, edge detector and pending flop.
module irq_gateway
    import irq_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  irq_raw,
    input  mode_e mode,
    input  logic  in_service,
    input  logic  claim_clr,
    output logic  pending
);

    logic sync1;
    logic s;
    logic s_d;
    logic set;
    logic pending_nxt;

    always_comb begin
        set = 1'b0;
        if (mode == EDGE) begin
            set = s & ~s_d;
        end else begin
            // a level source being claimed must not re-arm on the claim edge
            set = s & ~in_service & ~claim_clr;
        end
        pending_nxt = set | (pending & ~claim_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync1   <= irq_raw;
            s       <= sync1;
            s_d     <= s;
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Multi-source interrupt controller: gateways, priority arbiter, claim/complete
// handshake and a single-cycle configuration register port.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    output logic [31:0]       cfg_rdata,
    input  logic              claim_req,
    output logic              claim_ack,
    output logic [ID_W-1:0]   claim_id,
    input  logic              complete_req,
    input  logic [ID_W-1:0]   complete_id,
    output logic              ext_irq
);

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] in_service;
    logic [NUM_SRC-1:0] claim_clr;
    logic [NUM_SRC-1:0] complete_clr;
    logic [ID_W-1:0]    best_id;
    logic [ID_W-1:0]    best_id_q;
    logic [PRIO_W-1:0]  best_prio;
    logic               unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign claim_clr[g]    = claim_req && (best_id_q == ID_W'(g + 1));
        assign complete_clr[g] = complete_req && (complete_id == ID_W'(g + 1));

        irq_gateway u_gw (
            .clk        (clk),
            .rst        (rst),
            .irq_raw    (irq_src[g]),
            .mode       (mode_e'(mode[g])),
            .in_service (in_service[g]),
            .claim_clr  (claim_clr[g]),
            .pending    (pending[g])
        );
    end

    // The source being claimed this cycle is masked so a held claim_req
    // cannot hand out the same ID twice.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && enable[i] && !claim_clr[i] &&
                (prio[i] > threshold) && (prio[i] > best_prio)) begin
                best_prio = prio[i];
                best_id   = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_id_q  <= '0;
            ext_irq    <= 1'b0;
            claim_ack  <= 1'b0;
            claim_id   <= '0;
            in_service <= '0;
        end else begin
            best_id_q  <= best_id;
            ext_irq    <= (best_id != '0);
            claim_ack  <= claim_req;
            claim_id   <= claim_req ? best_id_q : '0;
            in_service <= (in_service & ~complete_clr) | claim_clr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable    <= '0;
            mode      <= '0;
            threshold <= '0;
            for (int k = 0; k < NUM_SRC; k++) begin
                prio[k] <= '0;
            end
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_ENABLE: enable    <= cfg_wdata[NUM_SRC-1:0];
                ADDR_MODE:   mode      <= cfg_wdata[NUM_SRC-1:0];
                ADDR_THRESH: threshold <= cfg_wdata[PRIO_W-1:0];
                default: begin
                    for (int k = 0; k < NUM_SRC; k++) begin
                        if (cfg_addr == ADDR_PRIO_BASE + 8'(k)) begin
                            prio[k] <= cfg_wdata[PRIO_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            ADDR_ENABLE: cfg_rdata[NUM_SRC-1:0] = enable;
            ADDR_MODE:   cfg_rdata[NUM_SRC-1:0] = mode;
            ADDR_THRESH: cfg_rdata[PRIO_W-1:0]  = threshold;
            ADDR_PEND:   cfg_rdata[NUM_SRC-1:0] = pending;
            ADDR_INSVC:  cfg_rdata[NUM_SRC-1:0] = in_service;
            default: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (cfg_addr == ADDR_PRIO_BASE + 8'(k)) begin
                        cfg_rdata[PRIO_W-1:0] = prio[k];
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised multi-source interrupt controller that drives the Processor's single `interupt` input.
- Replaces the one-bit, bench-driven interrupt pulse with the following per-source features:
  - synchronisation;
  - edge or level gateways;
  - per-source priority;
  - a global threshold;
  - a claim/complete handshake used by the trap handler.
- Configured through a simple single-cycle register port. The Processor's CSR/load-store path drives this port.

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..31; source IDs run 1..NUM_SRC, and ID 0 means none.
- PRIO_W, 3: priority width; priority 0 means never interrupt.
- ID_W, 5: width of the ID fields; must satisfy 2^ID_W > NUM_SRC.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- irq_src  in  NUM_SRC  raw asynchronous interrupt lines
- cfg_we  in  1  register write strobe
- cfg_addr  in  8  register address
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational from cfg_addr
- claim_req  in  1  one-cycle claim request
- claim_ack  out  1  one-cycle claim response
- claim_id  out  ID_W  claimed ID, valid while claim_ack is high
- complete_req  in  1  one-cycle completion strobe
- complete_id  in  ID_W  ID being completed
- ext_irq  out  1  interrupt to the Processor (`interupt`)

Behaviour:
- Reset (rst=0, asynchronous):
  - All flops clear: synchronisers, pending, in_service, enable, mode, priorities, threshold.
  - Outputs: ext_irq=0, claim_ack=0, claim_id=0. cfg_rdata reads 0 for all registers.
- Register map (reads of unmapped addresses return 0; writes to them are ignored):
  - 0x00 enable[NUM_SRC-1:0], RW.
  - 0x01 mode, RW: 1 = edge, 0 = level.
  - 0x02 threshold[PRIO_W-1:0], RW.
  - 0x03 pending, read-only; writes are ignored.
  - 0x04 in_service, read-only.
  - 0x10+k priority of source ID k+1, RW, for k < NUM_SRC.
  - Writes take effect at the next clock edge. Unused upper bits read as 0.
- Synchroniser and gateway:
  - Each source passes through a 2-flop synchroniser, followed by a delayed copy (s_d) for edge detection.
  - Edge mode: pending sets on s & ~s_d. Edges that arrive while the source is in_service are still captured; at most one is held.
  - Level mode: pending sets while s=1 and in_service=0 for that source.
  - Pending is cleared only by a claim. Disabling a source or raising its threshold does not clear pending.
- Arbitration:
  - A source is eligible when pending & enable & (prio > threshold). This also excludes prio=0.
  - The winner is the highest prio; ties go to the lowest ID.
  - best_id_q and ext_irq are registered every cycle. ext_irq = (best_id != 0).
- Latency: irq_src rises before edge E0, then:
  - sync1 at E0, sync2 at E1, pending at E2;
  - ext_irq is high after E3, so 4 edges in total.
- Claim:
  - claim_req sampled at edge E makes claim_ack=1 and claim_id=best_id_q for one cycle after E.
  - If claim_id≠0, the same edge clears pending[id] and sets in_service[id].
  - If best_id_q=0, the response is claim_id=0 with no state change.
  - claim_req held for several cycles is treated as one claim per cycle.
- Complete:
  - complete_req clears in_service[complete_id].
  - Ignored when complete_id is 0, when complete_id > NUM_SRC, or when that source is not in service.
- Simultaneous events on the same source at the same edge:
  - A new edge-mode set of pending wins over a claim clear.
  - A claim set of in_service wins over a complete clear.
  - A cfg write and arbitration: arbitration uses the pre-write values in that cycle.
- Reset asserted mid-operation clears all state immediately, including any held edges and in_service bits. There is no recovery of lost interrupts.

Decomposition:
- Package `irq_pkg` holds:
  - the register-address constants (ADDR_ENABLE, ADDR_MODE, ADDR_THRESH, ADDR_PEND, ADDR_INSVC, ADDR_PRIO_BASE);
  - the mode enum typedef (LEVEL, EDGE).
- Sub-module `irq_gateway`, one instance per source via generate: synchroniser, edge detector, and the pending flop with set/clear inputs.
- Arbiter: a combinational for-loop inside irq_controller.

Test Plan:
- Reset, then read every register: all read 0; ext_irq=0; a pulse on irq_src[0] produces no ext_irq because enable=0.
- Enable=0x01, mode=0x01, prio[ID1]=3, threshold=1; pulse irq_src[0] for 1 cycle:
  - ext_irq rises exactly 4 edges later;
  - claim returns claim_id=1; ext_irq falls the next cycle; pending=0 and in_service=0x01;
  - complete_id=1 clears in_service.
- Sources 2 and 5 are pending with prio 4 and 4, source 3 with prio 2: claim returns 2, then 5, then 3. A further claim returns 0 with no state change.
- Level mode, source 1 held high: after claim, pending stays 0 while in service. After complete, pending re-sets 2 edges later and ext_irq re-asserts.
- Threshold=5 with all priorities ≤5: ext_irq stays 0. Write threshold=2: ext_irq asserts 1 cycle later (pending retained).
- Same-edge events:
  - A new edge on source 1 at the same edge as its claim leaves pending=1.
  - claim and complete of ID 1 at the same edge leave in_service=1.
- Assert rst mid-claim: all state and outputs are 0 asynchronously, before the next clk edge.
